wb_mux: RTL and testbench

- Write-back source selector for the RV32I single-cycle core. It sits between the execute/memory stage and the register-file write port.
- Picks one of five 32-bit candidate results using a 3-bit wb_sel code, with a combinational path to the register file.
- Also provides a registered copy of the result and an illegal-select flag and counter, which the debug/trace logic uses.

---
 rtl/wb_mux.sv | 61 ++++++
 tb/tb_wb_mux.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wb_mux.sv
// Write-back source selector: combinational result mux for the register file,
// plus a registered copy and a saturating illegal-select counter for debug/trace.
module wb_mux #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       wb_sel,
  input  logic [XLEN-1:0]  alu_result,
  input  logic [XLEN-1:0]  mem_data,
  input  logic [XLEN-1:0]  pc_plus4,
  input  logic [XLEN-1:0]  u_imm,
  input  logic [XLEN-1:0]  pc_plus_imm,
  output logic [XLEN-1:0]  wb_data,
  output logic [XLEN-1:0]  wb_data_q,
  output logic             sel_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  logic [XLEN-1:0]  wb_data_reg;
  logic [CNT_W-1:0] illegal_cnt_reg;
  logic [CNT_W-1:0] illegal_cnt_next;

  // Reserved codes drive zero so the register file never sees a stale value.
  always_comb begin
    wb_data     = '0;
    sel_illegal = 1'b0;
    case (wb_sel)
      3'b000:  wb_data = alu_result;
      3'b001:  wb_data = mem_data;
      3'b010:  wb_data = pc_plus4;
      3'b011:  wb_data = u_imm;
      3'b100:  wb_data = pc_plus_imm;
      default: begin
        wb_data     = '0;
        sel_illegal = 1'b1;
      end
    endcase
  end

  always_comb begin
    illegal_cnt_next = illegal_cnt_reg;
    if (sel_illegal && !(&illegal_cnt_reg))
      illegal_cnt_next = illegal_cnt_reg + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_data_reg     <= '0;
      illegal_cnt_reg <= '0;
    end else begin
      wb_data_reg     <= wb_data;
      illegal_cnt_reg <= illegal_cnt_next;
    end
  end

  assign wb_data_q   = wb_data_reg;
  assign illegal_cnt = illegal_cnt_reg;

endmodule

// File: tb/tb_wb_mux.sv
// Directed bench for wb_mux: table of combinational vectors, then hand-written
// sequences for the registered copy, counter, reset priority and saturation.
module tb_wb_mux;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  wb_sel;
  logic [31:0] alu_result, mem_data, pc_plus4, u_imm, pc_plus_imm;
  logic [31:0] wb_data, wb_data_q;
  logic        sel_illegal;
  logic [15:0] illegal_cnt;
  logic [31:0] wb_data_s, wb_data_q_s;
  logic        sel_illegal_s;
  logic [3:0]  illegal_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_mux #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .pc_plus4(pc_plus4),
    .u_imm(u_imm), .pc_plus_imm(pc_plus_imm),
    .wb_data(wb_data), .wb_data_q(wb_data_q),
    .sel_illegal(sel_illegal), .illegal_cnt(illegal_cnt)
  );

  // Narrow-counter instance for the saturation sequence.
  wb_mux #(.XLEN(32), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .wb_sel(wb_sel),
    .alu_result(alu_result), .mem_data(mem_data), .pc_plus4(pc_plus4),
    .u_imm(u_imm), .pc_plus_imm(pc_plus_imm),
    .wb_data(wb_data_s), .wb_data_q(wb_data_q_s),
    .sel_illegal(sel_illegal_s), .illegal_cnt(illegal_cnt_s)
  );

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] alu, mem, pc4, uimm, pcimm;
    logic [31:0] exp_data;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  task automatic set_common();
    alu_result  = 32'hAAAA_AAAA;
    mem_data    = 32'hBBBB_BBBB;
    pc_plus4    = 32'h0000_0044;
    u_imm       = 32'h1234_5000;
    pc_plus_imm = 32'h0000_1000;
  endtask

  initial begin
    vecs[0]  = '{3'b000, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'hAAAAAAAA, 1'b0};
    vecs[1]  = '{3'b001, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'hBBBBBBBB, 1'b0};
    vecs[2]  = '{3'b010, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h00000044, 1'b0};
    vecs[3]  = '{3'b011, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h12345000, 1'b0};
    vecs[4]  = '{3'b100, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h00001000, 1'b0};
    vecs[5]  = '{3'b111, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h00000000, 1'b1};
    vecs[6]  = '{3'b101, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h00000000, 1'b1};
    vecs[7]  = '{3'b110, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'h00000044, 32'h12345000, 32'h00001000, 32'h00000000, 1'b1};
    // Unselected inputs toggled while mem_data stays selected.
    vecs[8]  = '{3'b001, 32'h55555555, 32'hBBBBBBBB, 32'hFFFFFFBB, 32'hEDCBAFFF, 32'hFFFFEFFF, 32'hBBBBBBBB, 1'b0};
    vecs[9]  = '{3'b001, 32'hFFFFFFFF, 32'hBBBBBBBB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hBBBBBBBB, 1'b0};
    vecs[10] = '{3'b001, 32'h00000000, 32'hBBBBBBBB, 32'h00000000, 32'h00000000, 32'h00000000, 32'hBBBBBBBB, 1'b0};
    // Top bits pass through untouched (no extension).
    vecs[11] = '{3'b100, 32'h00000000, 32'h00000000, 32'h00000000, 32'hFFFFF000, 32'h80000001, 32'h80000001, 1'b0};

    rst    = 1'b1;
    wb_sel = 3'b000;
    set_common();

    // Combinational checks, applied while rst is still asserted.
    for (int i = 0; i < 12; i++) begin
      wb_sel      = vecs[i].sel;
      alu_result  = vecs[i].alu;
      mem_data    = vecs[i].mem;
      pc_plus4    = vecs[i].pc4;
      u_imm       = vecs[i].uimm;
      pc_plus_imm = vecs[i].pcimm;
      #2;
      chk($sformatf("vec%0d sel=%03b wb_data", i, vecs[i].sel), wb_data, vecs[i].exp_data);
      chk($sformatf("vec%0d sel=%03b sel_illegal", i, vecs[i].sel), {31'b0, sel_illegal}, {31'b0, vecs[i].exp_ill});
    end

    // Reset for two cycles.
    set_common();
    wb_sel = 3'b000;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset wb_data_q", wb_data_q, 32'h0);
    chk("reset illegal_cnt", {16'b0, illegal_cnt}, 32'h0);
    chk("reset illegal_cnt_s", {28'b0, illegal_cnt_s}, 32'h0);

    // Registered path: one-cycle latency.
    rst    = 1'b0;
    wb_sel = 3'b010;
    #1;
    chk("q before edge", wb_data_q, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("q after edge sel=010", wb_data_q, 32'h0000_0044);
    chk("cnt idle on legal sel", {16'b0, illegal_cnt}, 32'h0);

    // Five illegal edges.
    wb_sel = 3'b111;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("cnt after 5 illegal", {16'b0, illegal_cnt}, 32'd5);
    chk("q under illegal sel", wb_data_q, 32'h0);

    // Reset wins over increment on the same edge.
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst priority cnt", {16'b0, illegal_cnt}, 32'h0);
    chk("rst priority q", wb_data_q, 32'h0);

    // Reset also wins over a nonzero data load.
    wb_sel = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk("rst blocks q load", wb_data_q, 32'h0);

    // Saturation on the 4-bit counter across 20 illegal edges.
    rst    = 1'b0;
    wb_sel = 3'b110;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("sat edge %0d", i), {28'b0, illegal_cnt_s}, (i > 15) ? 32'd15 : 32'(i));
    end
    chk("wide cnt after 20", {16'b0, illegal_cnt}, 32'd20);

    // Counter holds once the select is legal again.
    wb_sel = 3'b000;
    @(posedge clk);
    @(negedge clk);
    chk("cnt hold on legal", {16'b0, illegal_cnt}, 32'd20);
    chk("sat cnt hold", {28'b0, illegal_cnt_s}, 32'd15);
    chk("q follows alu", wb_data_q, 32'hAAAA_AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
